// File: rtl/common_pkg.sv
// Shared bus types for the core instruction port (ibus) and the cached
// memory bus (cbus) that leads to the memory arbiter.
package common_pkg;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'd0,
      AXI_BURST_INCR  = 2'd1,
      AXI_BURST_WRAP  = 2'd2
   } axi_burst_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      msize_t      size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [7:0]  len;
      axi_burst_t  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/icache_pkg.sv
// Instruction cache local types and default geometry.
//   OFF_BITS/IDX_BITS/TAG_BITS are derived from the default geometry;
//   the cache module re-derives them from its own parameters.
package icache_pkg;

   localparam int ICACHE_LINES = 16;
   localparam int ICACHE_WORDS = 4;
   localparam int OFF_BITS     = $clog2(ICACHE_WORDS);
   localparam int IDX_BITS     = $clog2(ICACHE_LINES);
   localparam int TAG_BITS     = 64 - 3 - OFF_BITS - IDX_BITS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FILL     = 2'd1,
      UNCACHED = 2'd2
   } icache_state_t;

   // Tag is kept right-aligned in a full-width field so any LINES/WORDS
   // override fits; the unused upper bits stay constant zero.
   typedef struct packed {
      logic        valid;
      logic [63:0] tag;
   } icache_meta_t;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data store: LINES x WORDS x 64b.
//   clk          : clock
//   ridx/roff    : combinational read address, rdata : read word
//   we/widx/woff : synchronous write enable and address, wdata : write word
// Contents are not reset.
module icache_data_ram #(
   parameter int LINES = 16,
   parameter int WORDS = 4,
   parameter int IW    = $clog2(LINES),
   parameter int OW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic [IW-1:0] ridx,
   input  logic [OW-1:0] roff,
   output logic [63:0]   rdata,
   input  logic          we,
   input  logic [IW-1:0] widx,
   input  logic [OW-1:0] woff,
   input  logic [63:0]   wdata
);

   logic [63:0] mem [LINES][WORDS];

   assign rdata = mem[ridx][roff];

   always_ff @(posedge clk) begin
      if (we) mem[widx][woff] <= wdata;
   end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache.
//   clk, reset : clock, synchronous active-high reset
//   ireq/iresp : core instruction port; hits answered in the same cycle
//   creq/cresp : cached bus; INCR line refill on miss, single beat for
//                uncached (addr[31]==0) fetches
//   perf_hit/perf_miss : saturating hit/miss counters, present only when
//                        ICACHE_PERF_EN is defined
module icache_direct
   import common_pkg::*;
   import icache_pkg::*;
#(
   parameter int LINES = ICACHE_LINES,
   parameter int WORDS = ICACHE_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  ibus_req_t   ireq,
   output ibus_resp_t  iresp,
   output cbus_req_t   creq,
   input  cbus_resp_t  cresp
`ifdef ICACHE_PERF_EN
   ,
   output logic [63:0] perf_hit,
   output logic [63:0] perf_miss
`endif
);

   localparam int OB  = $clog2(WORDS);
   localparam int IB  = $clog2(LINES);
   localparam int TOP = 3 + OB + IB;

   icache_state_t state, nstate;
   icache_meta_t  meta [LINES];
   logic [63:0]   lat_addr;
   logic [OB-1:0] beat_cnt;

   logic [OB-1:0] req_off;
   logic [IB-1:0] req_idx, lat_idx;
   logic [63:0]   req_tag, lat_tag, line_base, rdata;
   logic          hit, ram_we, meta_we, hit_evt, miss_evt;

   assign req_off   = ireq.addr[2+OB:3];
   assign req_idx   = ireq.addr[TOP-1:3+OB];
   assign req_tag   = ireq.addr >> TOP;
   assign lat_idx   = lat_addr[TOP-1:3+OB];
   assign lat_tag   = lat_addr >> TOP;
   assign line_base = ireq.addr & ~((64'd1 << (3 + OB)) - 64'd1);

   assign hit = ireq.valid && ireq.addr[31] && meta[req_idx].valid &&
                (meta[req_idx].tag == req_tag);

   icache_data_ram #(.LINES(LINES), .WORDS(WORDS)) u_ram (
      .clk  (clk),
      .ridx (req_idx),
      .roff (req_off),
      .rdata(rdata),
      .we   (ram_we),
      .widx (lat_idx),
      .woff (beat_cnt),
      .wdata(cresp.data)
   );

   always_comb begin
      nstate   = state;
      iresp    = '0;
      creq     = '0;
      ram_we   = 1'b0;
      meta_we  = 1'b0;
      hit_evt  = 1'b0;
      miss_evt = 1'b0;
      case (state)
         IDLE: begin
            if (ireq.valid) begin
               if (!ireq.addr[31]) begin
                  nstate = UNCACHED;
               end else if (hit) begin
                  iresp.addr_ok = 1'b1;
                  iresp.data_ok = 1'b1;
                  iresp.data    = ireq.addr[2] ? rdata[63:32] : rdata[31:0];
                  hit_evt       = 1'b1;
               end else begin
                  nstate   = FILL;
                  miss_evt = 1'b1;
               end
            end
         end
         FILL: begin
            creq.valid = 1'b1;
            creq.size  = MSIZE8;
            creq.addr  = lat_addr;
            creq.len   = 8'(WORDS - 1);
            creq.burst = AXI_BURST_INCR;
            if (cresp.ready) begin
               ram_we = 1'b1;
               if (cresp.last) begin
                  meta_we = 1'b1;
                  nstate  = IDLE;
               end
            end
         end
         UNCACHED: begin
            creq.valid = 1'b1;
            creq.size  = MSIZE4;
            creq.addr  = lat_addr;
            creq.len   = 8'd0;
            creq.burst = AXI_BURST_INCR;
            if (cresp.ready && cresp.last) begin
               // Deliver only if the core still wants this exact address;
               // after a redirect the data is simply dropped.
               if (ireq.valid && ireq.addr == lat_addr) begin
                  iresp.addr_ok = 1'b1;
                  iresp.data_ok = 1'b1;
                  iresp.data    = lat_addr[2] ? cresp.data[63:32] : cresp.data[31:0];
               end
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         lat_addr <= '0;
      end else begin
         state <= nstate;
         if (miss_evt)                lat_addr <= line_base;
         else if (nstate == UNCACHED && state == IDLE) lat_addr <= ireq.addr;
         if (ram_we) beat_cnt <= meta_we ? '0 : beat_cnt + 1'b1;
      end
   end

   // Only valid bits are reset; tags are don't-care while invalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) meta[i].valid <= 1'b0;
      end else if (meta_we) begin
         meta[lat_idx].valid <= 1'b1;
         meta[lat_idx].tag   <= lat_tag;
      end
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_hit  <= '0;
         perf_miss <= '0;
      end else begin
         if (hit_evt  && perf_hit  != '1) perf_hit  <= perf_hit  + 64'd1;
         if (miss_evt && perf_miss != '1) perf_miss <= perf_miss + 64'd1;
      end
   end
`endif

endmodule
